dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: EX/MEM CPU port vs. debug/loader port,
// single outstanding access, bounded debug starvation.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_memread,
  input  logic       cpu_memwrite,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_stall,
  input  logic       dbg_req,
  input  logic       dbg_we,
  input  logic [7:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  output logic [7:0] dbg_rdata,
  output logic       dbg_done,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_ACC,
    CPU_DONE,
    DBG_ACC
  } state_t;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t     state;
  state_t     state_nxt;
  acc_t       acc;
  acc_t       acc_nxt;
  logic [2:0] starve_cnt;
  logic [2:0] starve_nxt;
  logic       done_nxt;
  logic       cpu_active;
  logic       cpu_go;
  logic       dbg_go;
  logic       cpu_rd_upd;
  logic       dbg_rd_upd;

  assign cpu_active = cpu_memread | cpu_memwrite;

  // CPU keeps priority until a waiting debug request has seen LIMIT grants
  assign cpu_go = cpu_active &
                  (~dbg_req | (starve_cnt < LIMIT));
  assign dbg_go = ~cpu_go & dbg_req;

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    starve_nxt = starve_cnt;
    done_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!dbg_req)
          starve_nxt = 3'd0;
        unique case (1'b1)
          cpu_go: begin
            state_nxt     = CPU_ACC;
            acc_nxt.we    = cpu_memwrite;
            acc_nxt.addr  = cpu_addr;
            acc_nxt.wdata = cpu_wdata;
            if (dbg_req && starve_cnt != 3'd7)
              starve_nxt = starve_cnt + 3'd1;
          end
          dbg_go: begin
            state_nxt     = DBG_ACC;
            acc_nxt.we    = dbg_we;
            acc_nxt.addr  = dbg_addr;
            acc_nxt.wdata = dbg_wdata;
            starve_nxt    = 3'd0;
          end
          default: ;
        endcase
      end
      CPU_ACC: begin
        if (mem_ack)
          state_nxt = CPU_DONE;
      end
      CPU_DONE: begin
        state_nxt = IDLE;
      end
      DBG_ACC: begin
        if (mem_ack) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
    endcase
  end

  assign cpu_rd_upd = (state == CPU_ACC) &
                      mem_ack & ~acc.we;
  assign dbg_rd_upd = (state == DBG_ACC) &
                      mem_ack & ~acc.we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      acc        <= '0;
      starve_cnt <= 3'd0;
      dbg_done   <= 1'b0;
      cpu_rdata  <= 8'h00;
      dbg_rdata  <= 8'h00;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      starve_cnt <= starve_nxt;
      dbg_done   <= done_nxt;
      if (cpu_rd_upd)
        cpu_rdata <= mem_rdata;
      if (dbg_rd_upd)
        dbg_rdata <= mem_rdata;
    end
  end

  assign mem_req   = (state == CPU_ACC) |
                     (state == DBG_ACC);
  assign mem_we    = mem_req & acc.we;
  assign mem_addr  = acc.addr;
  assign mem_wdata = acc.wdata;

  assign cpu_stall = cpu_active &
                     (state != CPU_DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table of CPU accesses plus
// starvation, debug-drop and reset-abort sequences.
module tb_dmem_arbiter;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         delay;
    logic [7:0] rdata;
    logic       exp_we;
    int         exp_stall;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         delay;
    logic [7:0] rdata;
  } mem_t;

  logic       clk;
  logic       rst;
  logic       cpu_memread;
  logic       cpu_memwrite;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic       dbg_req;
  logic       dbg_we;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic [7:0] dbg_rdata;
  logic       dbg_done;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;

  logic       resp_ack;
  logic [7:0] resp_rdata;
  logic       man_ack;
  logic [7:0] man_rdata;
  logic       auto_mem;

  int checks;
  int errors;
  int cpu_done_cnt;
  mem_t exp_q[$];
  vec_t vecs[5];

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk),
    .rst(rst),
    .cpu_memread(cpu_memread),
    .cpu_memwrite(cpu_memwrite),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_req(dbg_req),
    .dbg_we(dbg_we),
    .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata),
    .dbg_done(dbg_done),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  assign mem_ack   = resp_ack | man_ack;
  assign mem_rdata = resp_ack ? resp_rdata : man_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // memory model: pops the expected access, checks it is held stable
  initial begin
    mem_t e;
    resp_ack   = 1'b0;
    resp_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (auto_mem && mem_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", 1, 0);
          e = '{1'b0, 8'h00, 8'h00, 0, 8'h00};
        end else begin
          e = exp_q.pop_front();
        end
        check("req_we", mem_we, e.we);
        check("req_addr", mem_addr, e.addr);
        check("req_wdata", mem_wdata, e.wdata);
        for (int k = 0; k < e.delay; k++) begin
          @(negedge clk);
          check("hold_req", mem_req, 1);
          check("hold_we", mem_we, e.we);
          check("hold_addr", mem_addr, e.addr);
          check("hold_wdata", mem_wdata, e.wdata);
        end
        resp_ack   = 1'b1;
        resp_rdata = e.rdata;
        @(negedge clk);
        resp_ack   = 1'b0;
      end
    end
  end

  task automatic cpu_txn(input vec_t v);
    int n;
    @(posedge clk); #1;
    cpu_memread  = v.rd;
    cpu_memwrite = v.wr;
    cpu_addr     = v.addr;
    cpu_wdata    = v.wdata;
    exp_q.push_back('{v.exp_we, v.addr, v.wdata,
                      v.delay, v.rdata});
    n = 0;
    @(negedge clk);
    while (cpu_stall && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("stall_cycles", n, v.exp_stall);
    check("cpu_rdata", cpu_rdata, v.exp_rdata);
    check("done_no_req", mem_req, 0);
    @(posedge clk); #1;
    cpu_memread  = 1'b0;
    cpu_memwrite = 1'b0;
  endtask

  initial begin
    int n;
    checks       = 0;
    errors       = 0;
    cpu_done_cnt = 0;
    auto_mem     = 1'b1;
    man_ack      = 1'b0;
    man_rdata    = 8'h00;
    rst          = 1'b0;
    cpu_memread  = 1'b1;
    cpu_memwrite = 1'b0;
    cpu_addr     = 8'h00;
    cpu_wdata    = 8'h00;
    dbg_req      = 1'b0;
    dbg_we       = 1'b0;
    dbg_addr     = 8'h00;
    dbg_wdata    = 8'h00;

    // reset values, stall follows cpu_active during reset
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_dbg_done", dbg_done, 0);
    check("rst_stall", cpu_stall, 1);
    cpu_memread = 1'b0;
    #1;
    check("rst_stall_off", cpu_stall, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    vecs[0] = '{1'b1, 1'b0, 8'h3C, 8'h00, 0, 8'hA5,
                1'b0, 2, 8'hA5};
    vecs[1] = '{1'b0, 1'b1, 8'h10, 8'h7E, 3, 8'hCC,
                1'b1, 5, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 8'h22, 8'h99, 1, 8'h11,
                1'b1, 3, 8'hA5};
    vecs[3] = '{1'b1, 1'b0, 8'hFF, 8'h00, 2, 8'h5A,
                1'b0, 4, 8'h5A};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 8'h00, 0, 8'h00,
                1'b0, 2, 8'h00};
    foreach (vecs[i]) cpu_txn(vecs[i]);

    // debug read vs. back-to-back CPU loads
    cpu_wdata = 8'h00;
    dbg_we    = 1'b0;
    dbg_addr  = 8'h05;
    dbg_wdata = 8'h00;
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{1'b0, 8'(8'hA0 + i), 8'h00,
                        0, 8'(8'h10 + i)});
    exp_q.push_back('{1'b0, 8'h05, 8'h00, 1, 8'hC3});
    exp_q.push_back('{1'b0, 8'hA4, 8'h00, 0, 8'h14});
    @(posedge clk); #1;
    cpu_memread = 1'b1;
    cpu_addr    = 8'hA0;
    dbg_req     = 1'b1;
    fork
      begin
        int m;
        for (int i = 0; i < 5; i++) begin
          m = 0;
          @(negedge clk);
          while (cpu_stall && m < 50) begin
            m++;
            @(negedge clk);
          end
          check("starve_cpu_rdata", cpu_rdata,
                8'(8'h10 + i));
          cpu_done_cnt++;
          @(posedge clk); #1;
          if (i < 4) cpu_addr = 8'(8'hA1 + i);
          else cpu_memread = 1'b0;
        end
      end
      begin
        int m;
        m = 0;
        @(negedge clk);
        while (!dbg_done && m < 100) begin
          m++;
          @(negedge clk);
        end
        check("starve_dbg_done", dbg_done, 1);
        check("grants_before_dbg", cpu_done_cnt, 4);
        check("starve_dbg_rdata", dbg_rdata, 8'hC3);
        @(posedge clk); #1;
        dbg_req = 1'b0;
      end
    join

    // debug write survives dbg_req dropping mid-access
    @(posedge clk); #1;
    dbg_req   = 1'b1;
    dbg_we    = 1'b1;
    dbg_addr  = 8'h40;
    dbg_wdata = 8'h3A;
    exp_q.push_back('{1'b1, 8'h40, 8'h3A, 3, 8'hEE});
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("drop_req_seen", mem_req, 1);
    @(posedge clk); #1;
    dbg_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!dbg_done && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("drop_dbg_done", dbg_done, 1);
    check("drop_dbg_rdata", dbg_rdata, 8'hC3);
    @(negedge clk);
    check("drop_done_pulse", dbg_done, 0);
    dbg_we    = 1'b0;
    dbg_wdata = 8'h00;

    // reset mid CPU access, then a stray ack
    auto_mem = 1'b0;
    @(posedge clk); #1;
    cpu_memread = 1'b1;
    cpu_addr    = 8'h77;
    @(negedge clk);
    @(negedge clk);
    check("abort_req_before", mem_req, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_mem_req", mem_req, 0);
    check("abort_mem_we", mem_we, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_cpu_rdata", cpu_rdata, 0);
    check("abort_dbg_rdata", dbg_rdata, 0);
    check("abort_stall", cpu_stall, 1);
    @(negedge clk);
    cpu_memread = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    man_ack   = 1'b1;
    man_rdata = 8'hEE;
    @(negedge clk);
    man_ack = 1'b0;
    check("stray_mem_req", mem_req, 0);
    check("stray_cpu_rdata", cpu_rdata, 0);
    check("stray_stall", cpu_stall, 0);
    auto_mem = 1'b1;
    cpu_txn('{1'b1, 1'b0, 8'h01, 8'h00, 0, 8'h42,
              1'b0, 2, 8'h42});

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
